pixel_stream_seq: RTL and testbench
===================================

// Module: pixel_stream_seq
// PURPOSE
//  Parametrised pixel-stream sequencer, next generation of the pixel/status front end ahead of the dsp/mem pair.
//  Sequences one frame through a 4-state FSM and XOR-scrambles CHANNELS pixels per beat.
//  Buffers the scrambled beats in a DEPTH-entry FIFO with valid/ready on both sides.
//  Drives the DSP param word, colour code and enable flag.
// PARAMETERS
//  PIX_W      8            bits per pixel channel
//  CHANNELS   1            pixels per beat; bus width = CHANNELS*PIX_W
//  DEPTH      8            FIFO entries, power of 2, >=2
//  FRAME_LEN  64           beats per frame, >=2
//  XOR_MASK   8'hCC        PIX_W-bit scramble mask, applied to every channel
//  PARAM1/2/3 8'h6D/CD/17  DSP param words
//  THRESH     8'h47        enable threshold on c
// PORTS
//  clk             in   1                 clock, rising edge
//  rstn            in   1                 reset, asynchronous, active-high
//  en              in   1                 global enable; 0 freezes FSM, FIFO, counters
//  pix_req         in   1                 frame request
//  start_dec       in   1                 arm-to-run trigger
//  config1         in   1                 force PARAM1
//  c               in   8                 enable compare operand
//  pixel_in        in   CHANNELS*PIX_W    input beat
//  pixel_in_valid  in   1                 input beat valid
//  pixel_in_ready  out  1                 input beat accepted when valid&ready
//  pixel_out       out  CHANNELS*PIX_W    FIFO head, scrambled
//  pixel_out_valid out  1                 output beat valid
//  pixel_out_ready in   1                 output beat consumed when valid&ready
//  status          out  2                 FSM state
//  colour          out  2                 registered copy of status
//  param           out  8                 DSP param word
//  fill            out  clog2(DEPTH)+1    FIFO occupancy
//  frame_done      out  1                 one-cycle pulse at end of frame
//  eno             out  1                 registered (c < THRESH)
// BEHAVIOUR
//  Reset values (rstn=1): status=IDLE, colour=0, fill=0, FIFO pointers=0, beat count=0, frame_done=0, eno=0.
//   FIFO contents are don't-care after reset.
//  Mid-operation reset discards the frame immediately; no frame_done pulse.
//  FSM encoding: IDLE=0, ARM=1, RUN=2, FLUSH=3. Transitions occur only when en=1.
//   IDLE->ARM when pix_req=1.
//   ARM->RUN when start_dec=1.
//   RUN->FLUSH on the accept of beat FRAME_LEN-1; the beat counter wraps to 0 at the same time.
//   FLUSH->IDLE when fill==0 and no push that cycle; frame_done=1 in the following cycle only.
//  pixel_in_ready = en & (status==RUN) & (fill<DEPTH). Combinational, no dependency on pixel_in_valid.
//  Push stores pixel_in ^ {CHANNELS{XOR_MASK}}. Pop advances the head.
//  pixel_out_valid = en & (fill!=0) & (status==RUN | status==FLUSH).
//   Show-ahead FIFO: a beat pushed at edge N is on pixel_out and valid after edge N.
//   Push-to-output latency is 1 cycle.
//  Simultaneous push and pop: fill unchanged, both pointers advance.
//   Full: push is blocked; pop alone is allowed.
//   Empty: pop is impossible because valid=0.
//  Pointers wrap modulo DEPTH. fill is a separate counter, range 0..DEPTH.
//  pixel_in_valid outside RUN is held off (ready=0) and never dropped or counted.
//  Beat counter is clog2(FRAME_LEN) bits; it increments only on accepted beats.
//  param: combinational. config1 ? PARAM1 : (status==ARM ? PARAM2 : PARAM3).
//  colour follows status with 1 cycle of delay and keeps updating when en=0.
//  eno is registered every cycle, unsigned 8-bit compare, independent of en.
//  en=0 mid-frame: ready=0 and valid=0, all state holds, and resuming loses no data.
// TESTING
//  1. Reset: pulse rstn=1 mid-RUN with fill=5 -> status=0, fill=0, valid=0, ready=0 next cycle, no frame_done.
//  2. Scramble, defaults: pix_req, start_dec, push 8'h00,8'hFF,8'h33
//     -> pixel_out reads 8'hCC,8'h33,8'hFF in order, each 1 cycle after its push.
//  3. Full/backpressure, DEPTH=8, pixel_out_ready=0: 8 beats accepted, fill=8, ready=0.
//     One pop -> fill=7, ready=1. Push+pop same cycle at fill=4 -> fill stays 4.
//  4. Frame end, FRAME_LEN=4, out_ready=1: 4th accepted beat moves RUN->FLUSH.
//     FIFO drains -> status=IDLE, frame_done high exactly 1 cycle. Beat counter reads 0 for the next frame.
//  5. Param/eno: config1=1 -> param=8'h6D; config1=0 in ARM -> 8'hCD, in IDLE -> 8'h17.
//     c=8'h46 -> eno=1 next cycle; c=8'h47 -> eno=0.
//  6. en gating, CHANNELS=2: drop en for 3 cycles mid-RUN with valid held -> no accepts, status/fill frozen.
//     16-bit data 16'h1234 emerges as 16'hDEF8 after en returns.

Source files
------------

// File: rtl/pixel_stream_seq.sv
// Pixel-stream sequencer: frame FSM, per-channel XOR scramble, show-ahead FIFO
// with valid/ready on both sides, plus DSP param/colour/enable side outputs.
module pixel_stream_seq #(
  parameter int               PIX_W     = 8,
  parameter int               CHANNELS  = 1,
  parameter int               DEPTH     = 8,
  parameter int               FRAME_LEN = 64,
  parameter logic [PIX_W-1:0] XOR_MASK  = 'hCC,
  parameter logic [7:0]       PARAM1    = 8'h6D,
  parameter logic [7:0]       PARAM2    = 8'hCD,
  parameter logic [7:0]       PARAM3    = 8'h17,
  parameter logic [7:0]       THRESH    = 8'h47
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       pix_req,
  input  logic                       start_dec,
  input  logic                       config1,
  input  logic [7:0]                 c,
  input  logic [CHANNELS*PIX_W-1:0]  pixel_in,
  input  logic                       pixel_in_valid,
  output logic                       pixel_in_ready,
  output logic [CHANNELS*PIX_W-1:0]  pixel_out,
  output logic                       pixel_out_valid,
  input  logic                       pixel_out_ready,
  output logic [1:0]                 status,
  output logic [1:0]                 colour,
  output logic [7:0]                 param,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       frame_done,
  output logic                       eno
);
  localparam int W  = CHANNELS * PIX_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [AW:0]   FULL_F   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     fill_q, fill_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [1:0]      colour_q, colour_d;
  logic            frame_done_q, frame_done_d;
  logic            eno_q, eno_d;
  logic [W-1:0]    mem_q [DEPTH];
  logic [CHANNELS-1:0][PIX_W-1:0] pix_scr;
  logic            push, pop;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    assign pix_scr[g] = pixel_in[g*PIX_W +: PIX_W] ^ XOR_MASK;
  end

  assign pixel_in_ready  = en & (state_q == RUN) & (fill_q != FULL_F);
  assign pixel_out_valid = en & (fill_q != '0) & ((state_q == RUN) | (state_q == FLUSH));
  assign push            = pixel_in_ready & pixel_in_valid;
  assign pop             = pixel_out_valid & pixel_out_ready;
  assign pixel_out       = mem_q[rd_ptr_q];
  assign status          = state_q;
  assign colour          = colour_q;
  assign fill            = fill_q;
  assign frame_done      = frame_done_q;
  assign eno             = eno_q;
  assign param           = config1 ? PARAM1 : ((state_q == ARM) ? PARAM2 : PARAM3);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    beat_d       = beat_q;
    frame_done_d = 1'b0;
    colour_d     = state_q;
    eno_d        = (c < THRESH);
    if (en) begin
      case (state_q)
        IDLE:  if (pix_req) state_d = ARM;
        ARM:   if (start_dec) state_d = RUN;
        RUN:   if (push && beat_q == LAST_BEAT) state_d = FLUSH;
        FLUSH: if (fill_q == '0 && !push) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        beat_d   = (beat_q == LAST_BEAT) ? '0 : beat_q + CW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_d = fill_q + (AW+1)'(1);
        2'b01:   fill_d = fill_q - (AW+1)'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      beat_q       <= '0;
      colour_q     <= '0;
      frame_done_q <= 1'b0;
      eno_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      beat_q       <= beat_d;
      colour_q     <= colour_d;
      frame_done_q <= frame_done_d;
      eno_q        <= eno_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by fill/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_scr;
  end
endmodule

// File: tb/tb_pixel_stream_seq.sv
// Directed bench: instance a uses defaults, instance b uses CHANNELS=2, FRAME_LEN=4.
module tb_pixel_stream_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // instance a (defaults)
  logic a_rstn = 1'b1, a_en = 1'b0, a_req = 1'b0, a_start = 1'b0, a_cfg = 1'b0;
  logic [7:0] a_c = 8'h00, a_in = 8'h00, a_out, a_param;
  logic a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0, a_fd, a_eno;
  logic [1:0] a_st, a_col;
  logic [3:0] a_fill;

  // instance b (two channels, short frame)
  logic b_rstn = 1'b1, b_en = 1'b0, b_req = 1'b0, b_start = 1'b0, b_cfg = 1'b0;
  logic [7:0] b_c = 8'h00, b_param;
  logic [15:0] b_in = 16'h0000, b_out;
  logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0, b_fd, b_eno;
  logic [1:0] b_st, b_col;
  logic [3:0] b_fill;

  pixel_stream_seq u_a (
    .clk(clk), .rstn(a_rstn), .en(a_en), .pix_req(a_req), .start_dec(a_start),
    .config1(a_cfg), .c(a_c), .pixel_in(a_in), .pixel_in_valid(a_iv),
    .pixel_in_ready(a_ir), .pixel_out(a_out), .pixel_out_valid(a_ov),
    .pixel_out_ready(a_or), .status(a_st), .colour(a_col), .param(a_param),
    .fill(a_fill), .frame_done(a_fd), .eno(a_eno));

  pixel_stream_seq #(.CHANNELS(2), .FRAME_LEN(4)) u_b (
    .clk(clk), .rstn(b_rstn), .en(b_en), .pix_req(b_req), .start_dec(b_start),
    .config1(b_cfg), .c(b_c), .pixel_in(b_in), .pixel_in_valid(b_iv),
    .pixel_in_ready(b_ir), .pixel_out(b_out), .pixel_out_valid(b_ov),
    .pixel_out_ready(b_or), .status(b_st), .colour(b_col), .param(b_param),
    .fill(b_fill), .frame_done(b_fd), .eno(b_eno));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    // reset state
    chk("rst_status", 32'(a_st), 0);
    chk("rst_fill", 32'(a_fill), 0);
    chk("rst_colour", 32'(a_col), 0);
    chk("rst_fd", 32'(a_fd), 0);
    chk("rst_eno", 32'(a_eno), 0);
    a_rstn = 1'b0; b_rstn = 1'b0;
    tick();

    // scramble on defaults
    a_en = 1'b1; a_req = 1'b1;
    tick();
    chk("to_arm", 32'(a_st), 1);
    chk("colour_lag", 32'(a_col), 0);
    a_req = 1'b0; a_start = 1'b1;
    tick();
    chk("to_run", 32'(a_st), 2);
    chk("colour_arm", 32'(a_col), 1);
    a_start = 1'b0; a_iv = 1'b1; a_in = 8'h00;
    #1 chk("ready_run", 32'(a_ir), 1);
    tick();
    chk("scr0_out", 32'(a_out), 32'hCC);
    chk("scr0_valid", 32'(a_ov), 1);
    a_in = 8'hFF; tick();
    a_in = 8'h33; tick();
    chk("scr_fill3", 32'(a_fill), 3);
    a_iv = 1'b0; a_or = 1'b1;
    #1 chk("scr_head0", 32'(a_out), 32'hCC);
    tick();
    chk("scr_head1", 32'(a_out), 32'h33);
    tick();
    chk("scr_head2", 32'(a_out), 32'hFF);
    tick();
    chk("scr_empty_fill", 32'(a_fill), 0);
    chk("scr_empty_valid", 32'(a_ov), 0);

    // full / backpressure
    a_or = 1'b0; a_iv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in = 8'(i);
      tick();
    end
    chk("full_fill", 32'(a_fill), 8);
    chk("full_ready", 32'(a_ir), 0);
    tick();
    chk("full_hold", 32'(a_fill), 8);
    a_iv = 1'b0; a_or = 1'b1;
    tick();
    chk("pop_fill7", 32'(a_fill), 7);
    chk("pop_ready", 32'(a_ir), 1);
    tick(); tick(); tick();
    chk("fill4", 32'(a_fill), 4);
    chk("head4", 32'(a_out), 32'hC8);
    a_iv = 1'b1; a_in = 8'hAA;
    tick();
    chk("pushpop_fill", 32'(a_fill), 4);
    chk("pushpop_head", 32'(a_out), 32'hC9);
    a_or = 1'b0; a_in = 8'h55;
    tick();
    chk("fill5", 32'(a_fill), 5);

    // asynchronous reset mid-RUN
    a_iv = 1'b0; a_rstn = 1'b1;
    #1;
    chk("arst_status", 32'(a_st), 0);
    chk("arst_fill", 32'(a_fill), 0);
    chk("arst_valid", 32'(a_ov), 0);
    chk("arst_ready", 32'(a_ir), 0);
    tick();
    a_rstn = 1'b0;
    tick();
    chk("arst_no_fd", 32'(a_fd), 0);
    chk("arst_idle", 32'(a_st), 0);

    // param / eno
    a_cfg = 1'b1;
    #1 chk("param_cfg", 32'(a_param), 32'h6D);
    a_cfg = 1'b0;
    #1 chk("param_idle", 32'(a_param), 32'h17);
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    chk("param_arm", 32'(a_param), 32'hCD);
    a_c = 8'h46;
    tick();
    chk("eno_46", 32'(a_eno), 1);
    a_c = 8'h47;
    tick();
    chk("eno_47", 32'(a_eno), 0);
    a_en = 1'b0; a_c = 8'h00;
    tick();
    chk("eno_en0", 32'(a_eno), 1);
    chk("arm_hold_en0", 32'(a_st), 1);

    // en gating on two channels
    b_en = 1'b1; b_req = 1'b1;
    tick();
    b_req = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_run", 32'(b_st), 2);
    b_iv = 1'b1; b_in = 16'h1234;
    tick();
    chk("b_fill1", 32'(b_fill), 1);
    b_in = 16'h5678; b_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("gate_ready", 32'(b_ir), 0);
      chk("gate_valid", 32'(b_ov), 0);
      tick();
      chk("gate_status", 32'(b_st), 2);
      chk("gate_fill", 32'(b_fill), 1);
    end
    b_en = 1'b1;
    #1;
    chk("resume_valid", 32'(b_ov), 1);
    chk("resume_out", 32'(b_out), 32'hDEF8);
    tick();
    chk("resume_fill", 32'(b_fill), 2);

    // frame end on FRAME_LEN=4
    b_or = 1'b1; b_in = 16'h0001;
    tick();
    chk("fe_beat3_run", 32'(b_st), 2);
    chk("fe_head", 32'(b_out), 32'h9AB4);
    b_in = 16'h0002;
    tick();
    chk("fe_flush", 32'(b_st), 3);
    chk("fe_fill2", 32'(b_fill), 2);
    b_iv = 1'b0;
    #1 chk("fe_flush_ready", 32'(b_ir), 0);
    tick();
    chk("fe_fill1", 32'(b_fill), 1);
    tick();
    chk("fe_fill0", 32'(b_fill), 0);
    chk("fe_still_flush", 32'(b_st), 3);
    chk("fe_fd_early", 32'(b_fd), 0);
    tick();
    chk("fe_idle", 32'(b_st), 0);
    chk("fe_fd_pulse", 32'(b_fd), 1);
    tick();
    chk("fe_fd_low", 32'(b_fd), 0);

    // next frame must end after exactly four beats again
    b_req = 1'b1;
    tick();
    b_req = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0; b_iv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_in = 16'(i);
      tick();
      chk("f2_run", 32'(b_st), 2);
    end
    tick();
    chk("f2_flush", 32'(b_st), 3);
    b_iv = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    fails++;
    $display("FAIL timeout: bench did not complete, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
